// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side handshakes of mem_port_arbiter.
// slave: arbiter view; master: core-plus-memory view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_type;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_type;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_type, m_ack, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, m_type
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_type, m_ack, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, m_type
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one shared memory port; ARB_PERF_EN adds a conflict counter.
// Latency: grant -> m_req next cycle, ready one cycle after m_ack (3 cycles minimum).
// Backpressure: requesters hold req until their ready pulse; memory stalls via m_ack up to TIMEOUT.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                owner,
  output logic                busy,
  output logic                err,
  output logic [31:0]         conflict_cnt
);

  localparam int             TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]     S_MAX  = 4'(STARVE_MAX);
  localparam logic [31:0]    NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    starve_cnt;
  logic [TW-1:0] timer;
  logic          timed_out;
  logic          grant_i, grant_d, ack_hit, to_hit;

  logic          m_we_q;
  logic [31:0]   m_addr_q, m_wdata_q, i_rdata_q, d_rdata_q;
  logic [2:0]    m_type_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless fetch has been passed over STARVE_MAX times in a row.
        grant_i = bus.i_req && (!bus.d_req || starve_cnt >= S_MAX);
        grant_d = bus.d_req && !grant_i;
        if (grant_i || grant_d) state_nxt = ACCESS;
      end
      ACCESS: begin
        ack_hit = bus.m_ack;
        to_hit  = !bus.m_ack && (timer == T_LAST);
        if (ack_hit || to_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_type_q   <= '0;
      owner      <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      starve_cnt <= '0;
      timer      <= '0;
      timed_out  <= 1'b0;
    end else begin
      timed_out <= to_hit;
      if (grant_i) begin
        m_we_q    <= 1'b0;
        m_addr_q  <= bus.i_addr;
        m_wdata_q <= '0;
        m_type_q  <= 3'b000;
        owner     <= 1'b0;
        timer     <= '0;
      end else if (grant_d) begin
        m_we_q    <= bus.d_we;
        m_addr_q  <= bus.d_addr;
        m_wdata_q <= bus.d_wdata;
        m_type_q  <= bus.d_type;
        owner     <= 1'b1;
        timer     <= '0;
      end
      if (state == IDLE) begin
        if (grant_i || !bus.i_req)
          starve_cnt <= '0;
        else if (grant_d && starve_cnt != 4'hF)
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (state == ACCESS && !ack_hit && !to_hit)
        timer <= timer + 1'b1;
      if (ack_hit) begin
        if (owner) d_rdata_q <= bus.m_rdata;
        else       i_rdata_q <= bus.m_rdata;
      end else if (to_hit) begin
        // Aborted fetch returns a NOP so the pipeline keeps flowing.
        if (owner) d_rdata_q <= '0;
        else       i_rdata_q <= NOP;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign err         = (state == RESP) && timed_out;
  assign bus.m_req   = (state == ACCESS);
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_type  = m_type_q;
  assign bus.i_ready = (state == RESP) && !owner;
  assign bus.d_ready = (state == RESP) && owner;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

`ifdef ARB_PERF_EN
  logic [31:0] conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_q <= '0;
    else if (state == IDLE && bus.i_req && bus.d_req)
      conflict_q <= conflict_q + 32'd1;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, variable-latency memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        owner, busy, err;
  logic [31:0] conflict_cnt;
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          n;

`ifdef ARB_PERF_EN
  localparam int EXP_CONF = 7;
`else
  localparam int EXP_CONF = 0;
`endif

  mem_port_arbiter_if mif ();

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .bus(mif.slave),
    .owner(owner), .busy(busy), .err(err), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        side;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  typ;
    int          len;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input logic side, input logic [31:0] rdata, input logic e,
                               input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               input logic [2:0] typ, input int len);
    exp_t x;
    x.side = side; x.rdata = rdata; x.err = e; x.addr = addr;
    x.we = we; x.wdata = wdata; x.typ = typ; x.len = len;
    sb.push_back(x);
  endfunction

  // Memory: acks after ack_delay ACCESS cycles, data = addr ^ 5A5A0000.
  initial begin
    int cnt = 0;
    mif.m_ack = 1'b0;
    mif.m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mif.m_ack = 1'b0;
      if (mif.m_req && !rst) begin
        if (cnt == ack_delay) begin
          mif.m_ack = 1'b1;
          mif.m_rdata = mif.m_addr ^ 32'h5A5A_0000;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Monitor: captures the access as it starts, checks it against the scoreboard on ready.
  int          acc_len = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we, cap_owner;
  logic [2:0]  cap_type;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) acc_len = 0;
    else begin
      if (mif.m_req) begin
        if (acc_len == 0) begin
          cap_addr = mif.m_addr; cap_wdata = mif.m_wdata; cap_we = mif.m_we;
          cap_type = mif.m_type; cap_owner = owner;
        end
        acc_len++;
      end
      if (err && !(mif.i_ready || mif.d_ready)) chk("err_without_ready", {31'd0, err}, 32'd0);
      if (mif.i_ready && mif.d_ready) chk("both_ready", {31'd0, mif.d_ready}, 32'd0);
      if (mif.i_ready || mif.d_ready) begin
        if (sb.size() == 0) chk("unexpected_ready", {30'd0, mif.i_ready, mif.d_ready}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("ready_side", {31'd0, mif.d_ready}, {31'd0, e.side});
          chk("rdata", e.side ? mif.d_rdata : mif.i_rdata, e.rdata);
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("owner", {31'd0, cap_owner}, {31'd0, e.side});
          chk("m_addr", cap_addr, e.addr);
          chk("m_we", {31'd0, cap_we}, {31'd0, e.we});
          chk("m_wdata", cap_wdata, e.wdata);
          chk("m_type", {29'd0, cap_type}, {29'd0, e.typ});
          chk("access_len", acc_len, e.len);
          chk("m_addr_hold", mif.m_addr, e.addr);
          chk("m_req_in_resp", {31'd0, mif.m_req}, 32'd0);
        end
        acc_len = 0;
      end
    end
  end

  task automatic wait_ready(input logic side, input int limit, output int cycles);
    logic seen;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
      seen = side ? mif.d_ready : mif.i_ready;
    end
    if (!seen) chk("ready_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    mif.i_req = 0; mif.i_addr = 0;
    mif.d_req = 0; mif.d_we = 0; mif.d_addr = 0; mif.d_wdata = 0; mif.d_type = 0;
    #2;
    chk("rst_m_req", {31'd0, mif.m_req}, 0);   chk("rst_m_we", {31'd0, mif.m_we}, 0);
    chk("rst_m_addr", mif.m_addr, 0);          chk("rst_m_wdata", mif.m_wdata, 0);
    chk("rst_m_type", {29'd0, mif.m_type}, 0); chk("rst_i_ready", {31'd0, mif.i_ready}, 0);
    chk("rst_d_ready", {31'd0, mif.d_ready}, 0); chk("rst_i_rdata", mif.i_rdata, 0);
    chk("rst_d_rdata", mif.d_rdata, 0);        chk("rst_err", {31'd0, err}, 0);
    chk("rst_owner", {31'd0, owner}, 0);       chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_conflict", conflict_cnt, 0);
    @(posedge clk); #1; rst = 0;

    // Single fetch, ack two cycles after m_req: ready on cycle 4.
    ack_delay = 2;
    mif.i_req = 1; mif.i_addr = 32'h100;
    push(0, 32'h5A5A_0100, 0, 32'h100, 0, 0, 3'b000, 3);
    wait_ready(0, 20, n);
    chk("fetch_latency", n, 4);
    mif.i_req = 0;
    idle_cycle();

    // Simultaneous requests: data store first, then fetch.
    ack_delay = 1;
    mif.i_req = 1; mif.i_addr = 32'h104;
    mif.d_req = 1; mif.d_we = 1; mif.d_addr = 32'h2000; mif.d_wdata = 32'hDEAD_BEEF; mif.d_type = 3'b010;
    push(1, 32'h5A5A_2000, 0, 32'h2000, 1, 32'hDEAD_BEEF, 3'b010, 2);
    push(0, 32'h5A5A_0104, 0, 32'h104, 0, 0, 3'b000, 2);
    wait_ready(1, 20, n);
    mif.d_req = 0;
    wait_ready(0, 20, n);
    chk("fetch_after_data_latency", n, 4);
    mif.i_req = 0;
    idle_cycle();

    // Starvation: fetch held, data re-requests; 4 data grants then fetch, then counter is clear.
    ack_delay = 0;
    mif.i_req = 1; mif.i_addr = 32'h200;
    mif.d_req = 1; mif.d_we = 0; mif.d_addr = 32'h3000; mif.d_wdata = 32'h1111_2222; mif.d_type = 3'b100;
    repeat (4) push(1, 32'h5A5A_3000, 0, 32'h3000, 0, 32'h1111_2222, 3'b100, 1);
    push(0, 32'h5A5A_0200, 0, 32'h200, 0, 0, 3'b000, 1);
    push(1, 32'h5A5A_3000, 0, 32'h3000, 0, 32'h1111_2222, 3'b100, 1);
    push(0, 32'h5A5A_0200, 0, 32'h200, 0, 0, 3'b000, 1);
    repeat (4) wait_ready(1, 20, n);
    wait_ready(0, 20, n);
    wait_ready(1, 20, n);
    mif.d_req = 0;
    wait_ready(0, 20, n);
    mif.i_req = 0;
    idle_cycle();

    // Timeouts: data load, then fetch; then ack on the last allowed cycle.
    ack_delay = 100000;
    mif.d_req = 1; mif.d_we = 0; mif.d_addr = 32'h4000; mif.d_wdata = 0; mif.d_type = 3'b001;
    push(1, 32'h0, 1, 32'h4000, 0, 0, 3'b001, 64);
    wait_ready(1, 200, n);
    chk("timeout_latency", n, 65);
    mif.d_req = 0;
    idle_cycle();
    mif.i_req = 1; mif.i_addr = 32'h500;
    push(0, 32'h0000_0013, 1, 32'h500, 0, 0, 3'b000, 64);
    wait_ready(0, 200, n);
    mif.i_req = 0;
    idle_cycle();
    ack_delay = 63;
    mif.d_req = 1; mif.d_addr = 32'h6000; mif.d_type = 3'b010;
    push(1, 32'h5A5A_6000, 0, 32'h6000, 0, 0, 3'b010, 64);
    wait_ready(1, 200, n);
    chk("late_ack_latency", n, 65);
    mif.d_req = 0;
    idle_cycle();
    chk("conflict_cnt", conflict_cnt, EXP_CONF);

    // Asynchronous reset in the middle of a data access.
    ack_delay = 100000;
    mif.d_req = 1; mif.d_we = 1; mif.d_addr = 32'h700; mif.d_wdata = 32'hCAFE_F00D;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_m_req", {31'd0, mif.m_req}, 1);
    rst = 1;
    #1;
    chk("midrst_m_req", {31'd0, mif.m_req}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_owner", {31'd0, owner}, 0);
    chk("midrst_err", {31'd0, err}, 0);
    chk("midrst_d_ready", {31'd0, mif.d_ready}, 0);
    chk("midrst_conflict", conflict_cnt, 0);
    mif.d_req = 0;
    @(posedge clk); #1; rst = 0;
    ack_delay = 1;
    mif.i_req = 1; mif.i_addr = 32'h800;
    push(0, 32'h5A5A_0800, 0, 32'h800, 0, 0, 3'b000, 2);
    wait_ready(0, 20, n);
    chk("post_rst_latency", n, 3);
    mif.i_req = 0;
    repeat (3) idle_cycle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
